icb_sram_slave: RTL and testbench
=================================

# icb_sram_slave

ICB extended three-channel slave that fronts a single-port word-addressed SRAM and answers burst read and write commands from the accelerator's ICB masters: the IA, weight and OA loaders. It provides the responder end of the `icb_ext_*` protocol. The block serves as the on-chip scratchpad model for block-level benches and as the local buffer memory behind the DSA interconnect. It serves one burst at a time, with no outstanding-command overlap.

## Interface
- `BUS_WIDTH`, 32: data width; beat size in bytes = BUS_WIDTH/8.
- `REG_WIDTH`, 32: address width.
- `DEPTH`, 1024: number of BUS_WIDTH words.
- `BASE_ADDR`, 32'h0: byte address of word 0.

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high. This is already decided; one clock domain.
- `icb_cmd_m`  in  `icb_ext_cmd_m_t`  fields: `valid`, `addr`, `read`, `len` [2:0]. Beats = len+1.
- `icb_cmd_s`  out  `icb_ext_cmd_s_t`  field: `ready`.
- `icb_wr_m`  in  `icb_ext_wr_m_t`  fields: `w_valid`, `wdata`, `wmask` (one bit per byte).
- `icb_wr_s`  out  `icb_ext_wr_s_t`  field: `w_ready`.
- `icb_rsp_s`  out  `icb_ext_rsp_s_t`  fields: `rsp_valid`, `rdata`, `err`.
- `icb_rsp_m`  in  `icb_ext_rsp_m_t`  field: `rsp_ready`.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- **States:** IDLE, RD_BURST, WR_BURST and WR_RSP.
- **IDLE**
  - `ready`=1.
  - On `valid & ready`, latch `addr`, `read` and `len`, and clear the beat counter and the error flag.
  - If `read`=1, go to RD_BURST. Otherwise go to WR_BURST.
- **Word index:** (addr − BASE_ADDR) >> 2. Each successive beat adds 1 to the index, which is equivalent to adding 4 to the byte address.
- **RD_BURST**
  - The `rdata` register loads `mem[idx]` on the accept edge and on every rsp handshake that is not the last beat.
  - `rsp_valid`=1 throughout the state.
  - The handshake is `rsp_valid & rsp_ready`.
  - After the handshake on beat len, return to IDLE.
- **WR_BURST**
  - `w_ready`=1.
  - Each `w_valid & w_ready` writes the bytes of `mem[idx]` whose `wmask` bit is 1 and increments the beat counter.
  - After beat len, go to WR_RSP.
- **WR_RSP**
  - `rsp_valid`=1, `rdata`=0, and `err` = sticky error flag for the burst.
  - After the handshake, return to IDLE.
- **Misaligned command** (addr[1:0]≠0):
  - Every beat of the burst errors.
  - No memory write occurs.
  - Read beats return `rdata`=0.
  - The full beat count is still exchanged.
- **Inputs outside their channel state:**
  - `w_valid` is ignored outside WR_BURST.
  - `rsp_ready` is ignored when `rsp_valid`=0.
- **Memory contents** are not reset. Data written by a completed burst is visible to any later read.

## Timing
- **Reset values:** `ready`=0 during reset and 1 from the first cycle after reset. `w_ready`=0, `rsp_valid`=0, `rdata`=0, `err`=0, `busy`=0.
- **Read latency:**
  - Command accepted at edge T → beat 0 is valid in the cycle after T.
  - A beat handshaken at edge U → the next beat is valid in the cycle after U.
  - With `rsp_ready` held at 1, the block returns one beat per cycle.
- **Backpressure:** while `rsp_ready`=0, `rsp_valid`, `rdata` and `err` hold stable.
- **Write:** with `w_valid` held at 1, one beat is accepted per cycle. The response is valid in the cycle after the last beat.
- **Return to IDLE:** `ready` returns to 1 in the cycle after the final rsp handshake, so back-to-back bursts have one bubble cycle.
- **Reset mid-burst:** the burst is abandoned and all outputs return to their reset values at the next edge. Write beats already handshaken remain in memory, and no response is issued.

## Configuration
- **`ICB_SRAM_BOUNDS_CHECK_EN` defined:**
  - Any beat whose index is ≥ DEPTH, or whose addr < BASE_ADDR, sets `err`=1 for that beat.
  - For writes, the flag is sticky and is reported in the WR_RSP response.
  - The beat is suppressed: no write, and `rdata`=0.
  - In-range beats of the same burst complete normally.
- **Macro undefined:**
  - The index wraps modulo DEPTH, with DEPTH a power of two.
  - `err` is driven only by misalignment.

## Test plan
- **Single read:** write 0xDEADBEEF to addr 0x10 with len=0 and wmask=4'hF; read addr 0x10 with len=0 and `rsp_ready`=1 → `rsp_valid` one cycle after accept, `rdata`=0xDEADBEEF, `err`=0.
- **Byte-masked write burst:** write len=3 from 0x40 with data 0x11111111…0x44444444, then rewrite 0x44 with 0xAABBCCDD and wmask=4'b0101 → reading 0x44 returns 0x22BB22DD.
- **Read burst under backpressure:** read len=7 from 0x0 while `rsp_ready` toggles 1,0,0,1,… → exactly 8 beats in address order, each held stable while `rsp_ready`=0, then `ready` returns to 1 one cycle after the last beat.
- **Misaligned command:** read addr 0x42 with len=1 → 2 beats with `err`=1 and `rdata`=0; a write to 0x42 → memory is unchanged and WR_RSP `err`=1.
- **Bounds:** with the macro and DEPTH=1024, write len=1 at 0xFFC → word 1023 is written, the response has `err`=1, and wrapped word 0 is unchanged. Without the macro → word 0 is written and `err`=0.
- **Reset mid-burst:** assert `rst` after 2 beats of a len=7 write → all outputs return to reset values at the next edge; words 0–1 hold new data and words 2–7 hold old data.

Source files
------------

// File: rtl/icb_sram_slave.sv
// ICB extended three-channel slave fronting a single-port word-addressed SRAM, serving one burst at a time.
// Optional build macro ICB_SRAM_BOUNDS_CHECK_EN: out-of-range beats error instead of wrapping modulo DEPTH.

package icb_ext_pkg;
    localparam int ICB_DATA_W = 32;
    localparam int ICB_ADDR_W = 32;

    typedef struct packed {
        logic                  valid;
        logic [ICB_ADDR_W-1:0] addr;
        logic                  read;
        logic [2:0]            len;
    } icb_ext_cmd_m_t;

    typedef struct packed {
        logic ready;
    } icb_ext_cmd_s_t;

    typedef struct packed {
        logic                    w_valid;
        logic [ICB_DATA_W-1:0]   wdata;
        logic [ICB_DATA_W/8-1:0] wmask;
    } icb_ext_wr_m_t;

    typedef struct packed {
        logic w_ready;
    } icb_ext_wr_s_t;

    typedef struct packed {
        logic                  rsp_valid;
        logic [ICB_DATA_W-1:0] rdata;
        logic                  err;
    } icb_ext_rsp_s_t;

    typedef struct packed {
        logic rsp_ready;
    } icb_ext_rsp_m_t;
endpackage

module icb_sram_slave
    import icb_ext_pkg::*;
#(
    parameter int                   BUS_WIDTH = ICB_DATA_W,
    parameter int                   REG_WIDTH = ICB_ADDR_W,
    parameter int                   DEPTH     = 1024,
    parameter logic [REG_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic           clk,
    input  logic           rst,
    input  icb_ext_cmd_m_t icb_cmd_m,
    output icb_ext_cmd_s_t icb_cmd_s,
    input  icb_ext_wr_m_t  icb_wr_m,
    output icb_ext_wr_s_t  icb_wr_s,
    output icb_ext_rsp_s_t icb_rsp_s,
    input  icb_ext_rsp_m_t icb_rsp_m,
    output logic           busy
);

    localparam int BYTES = BUS_WIDTH / 8;
    localparam int SHIFT = $clog2(BYTES);
    localparam int AW    = $clog2(DEPTH);
    localparam logic [REG_WIDTH-1:0] STEP = REG_WIDTH'(BYTES);

    typedef enum logic [1:0] {
        IDLE,
        RD_BURST,
        WR_BURST,
        WR_RSP
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic                   online;
    logic [REG_WIDTH-1:0]   addr_q;
    logic [2:0]             len_q;
    logic [2:0]             beat_q;
    logic                   err_q;
    logic                   rsp_err_q;
    logic [BUS_WIDTH-1:0]   rdata_q;
    logic [BUS_WIDTH-1:0]   mem [DEPTH];

    logic                   cmd_ready;
    logic                   w_ready;
    logic                   rsp_valid;
    logic [REG_WIDTH-1:0]   rd_addr;
    logic                   rd_err;
    logic                   wr_err;
    logic [BUS_WIDTH-1:0]   rd_word;
    logic                   last_beat;

    function automatic logic [AW-1:0] word_idx(input logic [REG_WIDTH-1:0] a);
        return AW'((a - BASE_ADDR) >> SHIFT);
    endfunction

`ifdef ICB_SRAM_BOUNDS_CHECK_EN
    localparam logic [REG_WIDTH-1:0] DEPTH_W = REG_WIDTH'(DEPTH);

    function automatic logic out_of_range(input logic [REG_WIDTH-1:0] a);
        logic [REG_WIDTH-1:0] off;
        off = a - BASE_ADDR;
        return (a < BASE_ADDR) || ((off >> SHIFT) >= DEPTH_W);
    endfunction

    assign rd_err = (|rd_addr[SHIFT-1:0]) | out_of_range(rd_addr);
    assign wr_err = (|addr_q[SHIFT-1:0]) | out_of_range(addr_q);
`else
    assign rd_err = |rd_addr[SHIFT-1:0];
    assign wr_err = |addr_q[SHIFT-1:0];
`endif

    // A read beat is fetched either from the incoming command or from the next burst address.
    assign rd_addr   = (state == IDLE) ? icb_cmd_m.addr : addr_q + STEP;
    assign rd_word   = rd_err ? '0 : mem[word_idx(rd_addr)];
    assign last_beat = (beat_q == len_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            online <= 1'b0;
        end else begin
            state  <= state_nxt;
            online <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        w_ready   = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = online;
                if (icb_cmd_m.valid && online)
                    state_nxt = icb_cmd_m.read ? RD_BURST : WR_BURST;
            end
            RD_BURST: begin
                rsp_valid = 1'b1;
                if (icb_rsp_m.rsp_ready && last_beat)
                    state_nxt = IDLE;
            end
            WR_BURST: begin
                w_ready = 1'b1;
                if (icb_wr_m.w_valid && last_beat)
                    state_nxt = WR_RSP;
            end
            WR_RSP: begin
                rsp_valid = 1'b1;
                if (icb_rsp_m.rsp_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q    <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            err_q     <= 1'b0;
            rsp_err_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (icb_cmd_m.valid && cmd_ready) begin
                        addr_q <= icb_cmd_m.addr;
                        len_q  <= icb_cmd_m.len;
                        beat_q <= '0;
                        err_q  <= 1'b0;
                        if (icb_cmd_m.read) begin
                            rdata_q   <= rd_word;
                            rsp_err_q <= rd_err;
                        end else begin
                            rdata_q   <= '0;
                            rsp_err_q <= 1'b0;
                        end
                    end
                end
                RD_BURST: begin
                    if (icb_rsp_m.rsp_ready) begin
                        beat_q <= beat_q + 3'd1;
                        addr_q <= addr_q + STEP;
                        if (!last_beat) begin
                            rdata_q   <= rd_word;
                            rsp_err_q <= rd_err;
                        end else begin
                            rdata_q   <= '0;
                            rsp_err_q <= 1'b0;
                        end
                    end
                end
                WR_BURST: begin
                    if (icb_wr_m.w_valid) begin
                        beat_q <= beat_q + 3'd1;
                        addr_q <= addr_q + STEP;
                        err_q  <= err_q | wr_err;
                        if (last_beat)
                            rsp_err_q <= err_q | wr_err;
                    end
                end
                WR_RSP: begin
                    if (icb_rsp_m.rsp_ready)
                        rsp_err_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Memory contents are deliberately not reset; erroring beats never touch the array.
    always_ff @(posedge clk) begin
        if (!rst && state == WR_BURST && icb_wr_m.w_valid && !wr_err) begin
            for (int b = 0; b < BYTES; b++) begin
                if (icb_wr_m.wmask[b])
                    mem[word_idx(addr_q)][b*8 +: 8] <= icb_wr_m.wdata[b*8 +: 8];
            end
        end
    end

    assign icb_cmd_s = '{ready: cmd_ready};
    assign icb_wr_s  = '{w_ready: w_ready};
    assign icb_rsp_s = '{rsp_valid: rsp_valid, rdata: rdata_q, err: rsp_err_q};
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_icb_sram_slave.sv
// Scoreboard bench for icb_sram_slave: stimulus pushes expected responses, a negedge monitor pops and compares.

module tb_icb_sram_slave;
    import icb_ext_pkg::*;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    icb_ext_cmd_m_t cmd_m;
    icb_ext_cmd_s_t cmd_s;
    icb_ext_wr_m_t  wr_m;
    icb_ext_wr_s_t  wr_s;
    icb_ext_rsp_s_t rsp_s;
    icb_ext_rsp_m_t rsp_m;
    logic           busy;

    always #5 clk = ~clk;

    icb_sram_slave #(
        .BUS_WIDTH(32),
        .REG_WIDTH(32),
        .DEPTH(1024),
        .BASE_ADDR(32'h0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .icb_cmd_m(cmd_m),
        .icb_cmd_s(cmd_s),
        .icb_wr_m(wr_m),
        .icb_wr_s(wr_s),
        .icb_rsp_s(rsp_s),
        .icb_rsp_m(rsp_m),
        .busy(busy)
    );

    typedef struct {
        logic [31:0] d;
        logic        e;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] wbuf[8];
    logic [3:0]  mbuf[8];
    logic [31:0] rexp[8];
    bit          bp_on = 1'b0;

`ifdef ICB_SRAM_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: hold-stability under backpressure and scoreboard pop on every rsp handshake.
    initial begin
        logic        pv;
        logic        pr;
        logic [31:0] pd;
        logic        pe;
        exp_t        e;
        pv = 1'b0; pr = 1'b0; pd = '0; pe = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pv = 1'b0;
            end else begin
                if (pv && !pr) begin
                    chk("hold_valid", 32'(rsp_s.rsp_valid), 32'h1);
                    chk("hold_rdata", rsp_s.rdata, pd);
                    chk("hold_err", 32'(rsp_s.err), 32'(pe));
                end
                if (rsp_s.rsp_valid && rsp_m.rsp_ready) begin
                    if (sbq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rsp_unexpected actual rdata=%h err=%b required no response",
                                 rsp_s.rdata, rsp_s.err);
                    end else begin
                        e = sbq.pop_front();
                        chk("rsp_rdata", rsp_s.rdata, e.d);
                        chk("rsp_err", 32'(rsp_s.err), 32'(e.e));
                    end
                end
                pv = rsp_s.rsp_valid;
                pr = rsp_m.rsp_ready;
                pd = rsp_s.rdata;
                pe = rsp_s.err;
            end
        end
    end

    task automatic issue_cmd(input logic [31:0] a, input logic rd, input logic [2:0] l);
        int n;
        n = 0;
        cmd_m.valid = 1'b1;
        cmd_m.addr  = a;
        cmd_m.read  = rd;
        cmd_m.len   = l;
        @(negedge clk);
        while (!cmd_s.ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_accept", 32'(cmd_s.ready), 32'h1);
        @(posedge clk);
        #1;
        cmd_m.valid = 1'b0;
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while (sbq.size() != 0 && n < limit) begin
            @(posedge clk);
            #1;
            n++;
            if (bp_on)
                rsp_m.rsp_ready = (n % 3 == 0);
        end
        chk("drain_pending", 32'(sbq.size()), 32'h0);
        rsp_m.rsp_ready = 1'b1;
    endtask

    task automatic write_burst(input logic [31:0] a, input logic [2:0] l, input logic exp_err);
        sbq.push_back('{d: 32'h0, e: exp_err});
        issue_cmd(a, 1'b0, l);
        for (int i = 0; i <= int'(l); i++) begin
            wr_m.w_valid = 1'b1;
            wr_m.wdata   = wbuf[i];
            wr_m.wmask   = mbuf[i];
            @(negedge clk);
            chk("w_ready", 32'(wr_s.w_ready), 32'h1);
            @(posedge clk);
            #1;
        end
        wr_m.w_valid = 1'b0;
        chk("wr_rsp_latency", 32'(rsp_s.rsp_valid), 32'h1);
        drain(20);
    endtask

    task automatic read_burst(input logic [31:0] a, input logic [2:0] l, input logic exp_err);
        for (int i = 0; i <= int'(l); i++)
            sbq.push_back('{d: rexp[i], e: exp_err});
        issue_cmd(a, 1'b1, l);
        chk("rd_latency", 32'(rsp_s.rsp_valid), 32'h1);
        drain(60);
        chk("ready_return", 32'(cmd_s.ready), 32'h1);
        chk("busy_clear", 32'(busy), 32'h0);
    endtask

    task automatic check_reset_outputs();
        chk("rst_ready", 32'(cmd_s.ready), 32'h0);
        chk("rst_w_ready", 32'(wr_s.w_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_s.rsp_valid), 32'h0);
        chk("rst_rdata", rsp_s.rdata, 32'h0);
        chk("rst_err", 32'(rsp_s.err), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cmd_m = '0;
        wr_m  = '0;
        rsp_m.rsp_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_reset", 32'(cmd_s.ready), 32'h1);

        // Single write then single read.
        wbuf[0] = 32'hDEADBEEF; mbuf[0] = 4'hF;
        write_burst(32'h10, 3'd0, 1'b0);
        rexp[0] = 32'hDEADBEEF;
        read_burst(32'h10, 3'd0, 1'b0);

        // Four-beat write, then byte-masked rewrite of 0x44.
        for (int i = 0; i < 4; i++) begin
            wbuf[i] = 32'h11111111 * (i + 1);
            mbuf[i] = 4'hF;
        end
        write_burst(32'h40, 3'd3, 1'b0);
        wbuf[0] = 32'hAABBCCDD; mbuf[0] = 4'b0101;
        write_burst(32'h44, 3'd0, 1'b0);
        rexp[0] = 32'h11111111; rexp[1] = 32'h22BB22DD;
        rexp[2] = 32'h33333333; rexp[3] = 32'h44444444;
        read_burst(32'h40, 3'd3, 1'b0);

        // Fill words 0..7, then read them back under 1,0,0 backpressure.
        for (int i = 0; i < 8; i++) begin
            wbuf[i] = 32'h1000 + i;
            mbuf[i] = 4'hF;
            rexp[i] = 32'h1000 + i;
        end
        write_burst(32'h0, 3'd7, 1'b0);
        bp_on = 1'b1;
        read_burst(32'h0, 3'd7, 1'b0);
        bp_on = 1'b0;

        // Misaligned read and write.
        rexp[0] = 32'h0; rexp[1] = 32'h0;
        read_burst(32'h42, 3'd1, 1'b1);
        wbuf[0] = 32'hFFFFFFFF; mbuf[0] = 4'hF;
        write_burst(32'h42, 3'd0, 1'b1);
        rexp[0] = 32'h11111111; rexp[1] = 32'h22BB22DD;
        read_burst(32'h40, 3'd1, 1'b0);

        // Burst crossing the top of the array.
        wbuf[0] = 32'hCAFE0001; wbuf[1] = 32'hCAFE0002;
        mbuf[0] = 4'hF;         mbuf[1] = 4'hF;
        write_burst(32'hFFC, 3'd1, BOUNDS);
        rexp[0] = 32'hCAFE0001;
        read_burst(32'hFFC, 3'd0, 1'b0);
        rexp[0] = BOUNDS ? 32'h1000 : 32'hCAFE0002;
        read_burst(32'h0, 3'd0, 1'b0);

        // Reset after two beats of an eight-beat write.
        issue_cmd(32'h0, 1'b0, 3'd7);
        for (int i = 0; i < 2; i++) begin
            wr_m.w_valid = 1'b1;
            wr_m.wdata   = 32'h2000 + i;
            wr_m.wmask   = 4'hF;
            @(negedge clk);
            chk("w_ready_mid", 32'(wr_s.w_ready), 32'h1);
            @(posedge clk);
            #1;
        end
        wr_m.w_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs();
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_midrst", 32'(cmd_s.ready), 32'h1);
        rexp[0] = 32'h2000; rexp[1] = 32'h2001;
        for (int i = 2; i < 8; i++)
            rexp[i] = 32'h1000 + i;
        read_burst(32'h0, 3'd7, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", 32'(sbq.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
